launch_queue: RTL and testbench

Parametrised in-order issue queue between decode and the two execution pipes. It buffers up to DEPTH decoded instructions and launches up to two per cycle from the head. A register scoreboard blocks RAW/WAW hazards, and writeback data is forwarded to the operands. Each launched instruction is held in a registered valid/ready output stage, one per pipe.

---
 rtl/launch_queue_pkg.sv | 59 +++++
 rtl/launch_queue_operand_bypass.sv | 48 ++++
 rtl/launch_queue.sv | 254 +++++++++++++++++++++++++
 tb/tb_launch_queue.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/launch_queue_pkg.sv
// launch_queue_pkg
//   Shared definitions for the launch queue: decode-word field layout,
//   instruction-type codes and the pipe-mapping helpers.
//   Decode word layout (low bits; the rest of the word is carried opaquely):
//     [4:0] rs   [5] rsv   [10:6] rt   [11] rtv   [16:12] rd   [17] rdv
//     [19:18] insttype
package launch_queue_pkg;

   localparam int REG_W       = 5;
   localparam int NREGS       = 32;
   localparam int NOPS        = 4;

   localparam int DC_RS_LO    = 0;
   localparam int DC_RSV      = 5;
   localparam int DC_RT_LO    = 6;
   localparam int DC_RTV      = 11;
   localparam int DC_RD_LO    = 12;
   localparam int DC_RDV      = 17;
   localparam int DC_TYPE_LO  = 18;
   localparam int DC_FIELDS_W = 20;

   typedef enum logic [1:0] {
      INSTTYPE_AL = 2'd0,
      INSTTYPE_BR = 2'd1,
      INSTTYPE_AG = 2'd2
   } insttype_e;

   // Field order mirrors the bit layout above, MSB first.
   typedef struct packed {
      logic [1:0]       itype;
      logic             rdv;
      logic [REG_W-1:0] rd;
      logic             rtv;
      logic [REG_W-1:0] rt;
      logic             rsv;
      logic [REG_W-1:0] rs;
   } dc_fields_t;

   function automatic dc_fields_t dc_decode(input logic [DC_FIELDS_W-1:0] lo);
      return dc_fields_t'(lo);
   endfunction

   // Pipe taken by H0. BR and AG are pinned; an AL steps aside to pipe1
   // only when the entry behind it is a BR that needs pipe0.
   function automatic logic h0_pipe_sel(input logic [1:0] t0,
                                        input logic       h1_present,
                                        input logic [1:0] t1);
      if (t0 == INSTTYPE_BR) return 1'b0;
      if (t0 == INSTTYPE_AG) return 1'b1;
      return h1_present && (t1 == INSTTYPE_BR);
   endfunction

   // Two BRs or two AGs compete for the same pipe and cannot pair.
   function automatic logic pair_compatible(input logic [1:0] t0,
                                            input logic [1:0] t1);
      return !((t0 == t1) && ((t0 == INSTTYPE_BR) || (t0 == INSTTYPE_AG)));
   endfunction

endpackage

// File: rtl/launch_queue_operand_bypass.sv
// operand_bypass
//   One source operand of a head entry: scoreboard check, writeback match
//   and data select.
//   Ports:
//     valid    operand is used by the instruction (rsv/rtv)
//     addr     register address of the operand
//     busy     scoreboard, one bit per architectural register
//     wb_*     writeback ports, index 0 is the newest
//     rf_data  register-file read data for addr (same cycle)
//     ready    operand can be consumed this cycle
//     data     operand value (0 when the operand is unused)
module operand_bypass
   import launch_queue_pkg::*;
#(
   parameter int NWB    = 4,
   parameter int DATA_W = 32
) (
   input  logic                        valid,
   input  logic [REG_W-1:0]            addr,
   input  logic [NREGS-1:0]            busy,
   input  logic [NWB-1:0]              wb_en,
   input  logic [NWB-1:0][REG_W-1:0]   wb_addr,
   input  logic [NWB-1:0][DATA_W-1:0]  wb_data,
   input  logic [DATA_W-1:0]           rf_data,
   output logic                        ready,
   output logic [DATA_W-1:0]           data
);

   logic [NWB-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NWB; i++) begin
         hit[i] = wb_en[i] && (wb_addr[i] == addr);
      end
   end

   // Scan from the oldest port down so the newest (lowest index) match wins.
   always_comb begin
      data = rf_data;
      for (int i = NWB - 1; i >= 0; i--) begin
         if (hit[i]) data = wb_data[i];
      end
      if (!valid) data = '0;
      ready = !valid || !busy[addr] || (|hit);
   end

endmodule

// File: rtl/launch_queue.sv
// launch_queue
//   In-order issue queue between decode and the two execution pipes. Holds
//   up to DEPTH decoded instructions and launches up to two per cycle from
//   the head, blocking RAW/WAW hazards through a register scoreboard and
//   forwarding writeback data into the operands.
//   Ports:
//     clk, rst               clock; synchronous active-low reset
//     flush                  mispredict flush
//     in_valid, in_ready     decode slots (bit1 only with bit0); room for two
//     in0_*, in1_*           decode slot payloads (pc, npc, decode word)
//     rf_raddr, rf_rdata     register-file reads for H0 rs/rt, H1 rs/rt
//     wb_en/addr/data        writeback ports, index 0 newest
//     exk_*                  registered output stage per pipe k = 0, 1
//
//   Handshake: exk_valid/exk_ready follow strict valid/ready. A transfer
//   happens on a rising edge where both are high; while exk_valid is high
//   and exk_ready is low the payload holds steady. The pipe register may be
//   reloaded in the same cycle it hands off, so a pipe runs at full rate.
module launch_queue
   import launch_queue_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int DC_W   = 128,
   parameter int NWB    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [1:0]                  in_valid,
   output logic                        in_ready,
   input  logic [PC_W-1:0]             in0_pc,
   input  logic [PC_W-1:0]             in1_pc,
   input  logic [PC_W-1:0]             in0_npc,
   input  logic [PC_W-1:0]             in1_npc,
   input  logic [DC_W-1:0]             in0_dc,
   input  logic [DC_W-1:0]             in1_dc,
   output logic [NOPS-1:0][REG_W-1:0]  rf_raddr,
   input  logic [NOPS-1:0][DATA_W-1:0] rf_rdata,
   input  logic [NWB-1:0]              wb_en,
   input  logic [NWB-1:0][REG_W-1:0]   wb_addr,
   input  logic [NWB-1:0][DATA_W-1:0]  wb_data,
   output logic                        ex0_valid,
   input  logic                        ex0_ready,
   output logic [PC_W-1:0]             ex0_pc,
   output logic [PC_W-1:0]             ex0_npc,
   output logic [DC_W-1:0]             ex0_dc,
   output logic [DATA_W-1:0]           ex0_op1,
   output logic [DATA_W-1:0]           ex0_op2,
   output logic                        ex1_valid,
   input  logic                        ex1_ready,
   output logic [PC_W-1:0]             ex1_pc,
   output logic [PC_W-1:0]             ex1_npc,
   output logic [DC_W-1:0]             ex1_dc,
   output logic [DATA_W-1:0]           ex1_op1,
   output logic [DATA_W-1:0]           ex1_op2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // ---------------------------------------------------------------- storage
   logic [PC_W-1:0]  mem_pc  [DEPTH];
   logic [PC_W-1:0]  mem_npc [DEPTH];
   logic [DC_W-1:0]  mem_dc  [DEPTH];

   logic [PTR_W-1:0] head, tail, head1, tail1;
   logic [CNT_W-1:0] count, n_enq, n_deq;
   logic             enq0, enq1;
   logic [NREGS-1:0] busy, busy_nxt;

   assign head1    = head + PTR_W'(1);
   assign tail1    = tail + PTR_W'(1);
   assign in_ready = (count <= CNT_W'(DEPTH - 2));

   // Slot 1 is only taken together with slot 0.
   assign enq0  = !flush && in_ready && in_valid[0];
   assign enq1  = enq0 && in_valid[1];
   assign n_enq = CNT_W'(enq0) + CNT_W'(enq1);

   always_ff @(posedge clk) begin
      if (enq0) begin
         mem_pc[tail]  <= in0_pc;
         mem_npc[tail] <= in0_npc;
         mem_dc[tail]  <= in0_dc;
      end
      if (enq1) begin
         mem_pc[tail1]  <= in1_pc;
         mem_npc[tail1] <= in1_npc;
         mem_dc[tail1]  <= in1_dc;
      end
   end

   // ------------------------------------------------------------------ heads
   logic [PC_W-1:0]  h0_pc, h0_npc, h1_pc, h1_npc;
   logic [DC_W-1:0]  h0_dc, h1_dc;
   dc_fields_t       f0, f1;
   logic             h0_present, h1_present;

   assign h0_pc      = mem_pc[head];
   assign h0_npc     = mem_npc[head];
   assign h0_dc      = mem_dc[head];
   assign h1_pc      = mem_pc[head1];
   assign h1_npc     = mem_npc[head1];
   assign h1_dc      = mem_dc[head1];
   assign f0         = dc_decode(h0_dc[DC_FIELDS_W-1:0]);
   assign f1         = dc_decode(h1_dc[DC_FIELDS_W-1:0]);
   assign h0_present = (count != '0);
   assign h1_present = (count >= CNT_W'(2));

   assign rf_raddr[0] = f0.rs;
   assign rf_raddr[1] = f0.rt;
   assign rf_raddr[2] = f1.rs;
   assign rf_raddr[3] = f1.rt;

   // --------------------------------------------------------------- operands
   logic [NOPS-1:0]             op_v, op_rdy;
   logic [NOPS-1:0][DATA_W-1:0] op_data;

   assign op_v = {f1.rtv, f1.rsv, f0.rtv, f0.rsv};

   for (genvar g = 0; g < NOPS; g++) begin : g_byp
      operand_bypass #(
         .NWB    (NWB),
         .DATA_W (DATA_W)
      ) u_byp (
         .valid   (op_v[g]),
         .addr    (rf_raddr[g]),
         .busy    (busy),
         .wb_en   (wb_en),
         .wb_addr (wb_addr),
         .wb_data (wb_data),
         .rf_data (rf_rdata[g]),
         .ready   (op_rdy[g]),
         .data    (op_data[g])
      );
   end

   // ----------------------------------------------------------------- launch
   logic [1:0]       ex_valid, ex_ready, pipe_free, load, sel_h1;
   logic [1:0][PC_W-1:0]   ex_pc, ex_npc;
   logic [1:0][DC_W-1:0]   ex_dc;
   logic [1:0][DATA_W-1:0] ex_op1, ex_op2;
   logic             h0_pipe, h1_pipe, h0_waw_ok, h1_waw_ok, pair_hazard;
   logic             h0_go, h1_go;

   assign ex_ready  = {ex1_ready, ex0_ready};
   assign pipe_free = ~ex_valid | ex_ready;

   // The mapping depends only on the types at the head, so H0 never waits
   // on whether H1 itself is able to launch.
   assign h0_pipe = h0_pipe_sel(f0.itype, h1_present, f1.itype);
   assign h1_pipe = !h0_pipe;

   assign h0_waw_ok   = !(f0.rdv && busy[f0.rd]);
   assign h1_waw_ok   = !(f1.rdv && busy[f1.rd]);
   assign pair_hazard = f0.rdv && ((f1.rsv && (f1.rs == f0.rd)) ||
                                   (f1.rtv && (f1.rt == f0.rd)) ||
                                   (f1.rdv && (f1.rd == f0.rd)));

   assign h0_go = !flush && h0_present && op_rdy[0] && op_rdy[1] &&
                  h0_waw_ok && pipe_free[h0_pipe];
   assign h1_go = h0_go && h1_present && pair_compatible(f0.itype, f1.itype) &&
                  !pair_hazard && op_rdy[2] && op_rdy[3] && h1_waw_ok &&
                  pipe_free[h1_pipe];

   assign n_deq = CNT_W'(h0_go) + CNT_W'(h1_go);

   assign load[0]   = (h0_go && !h0_pipe) || (h1_go && !h1_pipe);
   assign load[1]   = (h0_go &&  h0_pipe) || (h1_go &&  h1_pipe);
   assign sel_h1[0] = h1_go && !h1_pipe;
   assign sel_h1[1] = h1_go &&  h1_pipe;

   // ------------------------------------------------------- queue pointers
   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(n_deq);
         tail  <= tail + PTR_W'(n_enq);
         count <= count + n_enq - n_deq;
      end
   end

   // ------------------------------------------------------------- scoreboard
   // Clears are applied before sets so an issue wins over a same-cycle
   // writeback or flush drop of the same register.
   always_comb begin
      busy_nxt = busy;
      for (int i = 0; i < NWB; i++) begin
         if (wb_en[i]) busy_nxt[wb_addr[i]] = 1'b0;
      end
      if (flush) begin
         for (int k = 0; k < 2; k++) begin
            if (ex_valid[k] && !ex_ready[k] && ex_dc[k][DC_RDV])
               busy_nxt[ex_dc[k][DC_RD_LO +: REG_W]] = 1'b0;
         end
      end
      if (h0_go && f0.rdv) busy_nxt[f0.rd] = 1'b1;
      if (h1_go && f1.rdv) busy_nxt[f1.rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) busy <= '0;
      else      busy <= busy_nxt;
   end

   // ----------------------------------------------------------- output stage
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_valid <= '0;
         ex_pc    <= '0;
         ex_npc   <= '0;
         ex_dc    <= '0;
         ex_op1   <= '0;
         ex_op2   <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (load[k]) begin
               ex_valid[k] <= 1'b1;
               ex_pc[k]    <= sel_h1[k] ? h1_pc      : h0_pc;
               ex_npc[k]   <= sel_h1[k] ? h1_npc     : h0_npc;
               ex_dc[k]    <= sel_h1[k] ? h1_dc      : h0_dc;
               ex_op1[k]   <= sel_h1[k] ? op_data[2] : op_data[0];
               ex_op2[k]   <= sel_h1[k] ? op_data[3] : op_data[1];
            end else if (flush || ex_ready[k]) begin
               ex_valid[k] <= 1'b0;
            end
         end
      end
   end

   assign ex0_valid = ex_valid[0];
   assign ex0_pc    = ex_pc[0];
   assign ex0_npc   = ex_npc[0];
   assign ex0_dc    = ex_dc[0];
   assign ex0_op1   = ex_op1[0];
   assign ex0_op2   = ex_op2[0];
   assign ex1_valid = ex_valid[1];
   assign ex1_pc    = ex_pc[1];
   assign ex1_npc   = ex_npc[1];
   assign ex1_dc    = ex_dc[1];
   assign ex1_op1   = ex_op1[1];
   assign ex1_op2   = ex_op2[1];

endmodule

// File: tb/tb_launch_queue.sv
// tb_launch_queue
//   Directed scenarios followed by randomized traffic; every cycle the DUT
//   outputs are compared against a queue-based reference model.
module tb_launch_queue;

   localparam int DEPTH  = 8;
   localparam int PC_W   = 32;
   localparam int DATA_W = 32;
   localparam int DC_W   = 128;
   localparam int NWB    = 4;
   localparam int AL = 0, BR = 1, AG = 2;

   // ------------------------------------------------------- clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                        rst = 1'b0;
   logic                        flush = 1'b0;
   logic [1:0]                  in_valid = '0;
   logic                        in_ready;
   logic [PC_W-1:0]             in0_pc = '0, in1_pc = '0, in0_npc = '0, in1_npc = '0;
   logic [DC_W-1:0]             in0_dc = '0, in1_dc = '0;
   logic [3:0][4:0]             rf_raddr;
   logic [3:0][DATA_W-1:0]      rf_rdata;
   logic [NWB-1:0]              wb_en = '0;
   logic [NWB-1:0][4:0]         wb_addr = '0;
   logic [NWB-1:0][DATA_W-1:0]  wb_data = '0;
   logic                        ex0_valid, ex1_valid;
   logic                        ex0_ready = 1'b1, ex1_ready = 1'b1;
   logic [PC_W-1:0]             ex0_pc, ex0_npc, ex1_pc, ex1_npc;
   logic [DC_W-1:0]             ex0_dc, ex1_dc;
   logic [DATA_W-1:0]           ex0_op1, ex0_op2, ex1_op1, ex1_op2;

   logic [DATA_W-1:0]           rf_model [32];

   launch_queue #(
      .DEPTH (DEPTH), .PC_W (PC_W), .DATA_W (DATA_W), .DC_W (DC_W), .NWB (NWB)
   ) dut (
      .clk (clk), .rst (rst), .flush (flush),
      .in_valid (in_valid), .in_ready (in_ready),
      .in0_pc (in0_pc), .in1_pc (in1_pc), .in0_npc (in0_npc), .in1_npc (in1_npc),
      .in0_dc (in0_dc), .in1_dc (in1_dc),
      .rf_raddr (rf_raddr), .rf_rdata (rf_rdata),
      .wb_en (wb_en), .wb_addr (wb_addr), .wb_data (wb_data),
      .ex0_valid (ex0_valid), .ex0_ready (ex0_ready), .ex0_pc (ex0_pc),
      .ex0_npc (ex0_npc), .ex0_dc (ex0_dc), .ex0_op1 (ex0_op1), .ex0_op2 (ex0_op2),
      .ex1_valid (ex1_valid), .ex1_ready (ex1_ready), .ex1_pc (ex1_pc),
      .ex1_npc (ex1_npc), .ex1_dc (ex1_dc), .ex1_op1 (ex1_op1), .ex1_op2 (ex1_op2)
   );

   // Register file: static random contents, x0 reads zero.
   always_comb begin
      for (int i = 0; i < 4; i++) rf_rdata[i] = rf_model[rf_raddr[i]];
   end

   // ------------------------------------------------------ reference model
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] npc;
      logic [DC_W-1:0] dc;
   } entry_t;

   entry_t            q[$];
   logic [31:0]       m_busy;
   logic              m_exv [2];
   entry_t            m_ex  [2];
   logic [DATA_W-1:0] m_op1 [2];
   logic [DATA_W-1:0] m_op2 [2];

   function automatic int f_rs  (logic [DC_W-1:0] d); return int'(d[4:0]);   endfunction
   function automatic bit f_rsv (logic [DC_W-1:0] d); return d[5];            endfunction
   function automatic int f_rt  (logic [DC_W-1:0] d); return int'(d[10:6]);  endfunction
   function automatic bit f_rtv (logic [DC_W-1:0] d); return d[11];           endfunction
   function automatic int f_rd  (logic [DC_W-1:0] d); return int'(d[16:12]); endfunction
   function automatic bit f_rdv (logic [DC_W-1:0] d); return d[17];           endfunction
   function automatic int f_typ (logic [DC_W-1:0] d); return int'(d[19:18]); endfunction

   // Operand as the spec defines it: ready when unused, not busy, or written
   // back this cycle; value from the newest matching writeback, else the file.
   task automatic opnd(input bit v, input int a, output bit rdy,
                       output logic [DATA_W-1:0] val);
      bit found;
      found = 1'b0;
      val   = rf_model[a];
      for (int i = 0; i < NWB; i++) begin
         if (!found && wb_en[i] && int'(wb_addr[i]) == a) begin
            found = 1'b1;
            val   = wb_data[i];
         end
      end
      rdy = !v || !m_busy[a] || found;
      if (!v) val = '0;
   endtask

   task automatic model_step();
      logic [31:0]       nb;
      bit                pf [2];
      bit                rdy_in [2];
      bit                loaded [2];
      bit                ra1, ra2, rb1, rb2, can_enq, hazard, compat;
      int                nl, p0, p1, t0, t1;
      entry_t            e0, e1;
      logic [DATA_W-1:0] a1, a2, b1, b2;

      rdy_in[0] = ex0_ready;
      rdy_in[1] = ex1_ready;
      if (!rst) begin
         q.delete();
         m_busy = '0;
         for (int k = 0; k < 2; k++) begin
            m_exv[k] = 1'b0; m_ex[k] = '0; m_op1[k] = '0; m_op2[k] = '0;
         end
         return;
      end
      can_enq = (q.size() <= DEPTH - 2);
      for (int k = 0; k < 2; k++) pf[k] = !m_exv[k] || rdy_in[k];
      nl = 0; p0 = 0; p1 = 1;
      e0 = '0; e1 = '0; a1 = '0; a2 = '0; b1 = '0; b2 = '0;
      if (!flush && q.size() >= 1) begin
         e0 = q[0];
         t0 = f_typ(e0.dc);
         t1 = (q.size() >= 2) ? f_typ(q[1].dc) : -1;
         opnd(f_rsv(e0.dc), f_rs(e0.dc), ra1, a1);
         opnd(f_rtv(e0.dc), f_rt(e0.dc), ra2, a2);
         if (t0 == BR)      p0 = 0;
         else if (t0 == AG) p0 = 1;
         else               p0 = (t1 == BR) ? 1 : 0;
         p1 = 1 - p0;
         if (ra1 && ra2 && !(f_rdv(e0.dc) && m_busy[f_rd(e0.dc)]) && pf[p0]) begin
            nl = 1;
            if (q.size() >= 2) begin
               e1 = q[1];
               opnd(f_rsv(e1.dc), f_rs(e1.dc), rb1, b1);
               opnd(f_rtv(e1.dc), f_rt(e1.dc), rb2, b2);
               compat = !(t1 == t0 && t0 != AL);
               hazard = f_rdv(e0.dc) &&
                        ((f_rsv(e1.dc) && f_rs(e1.dc) == f_rd(e0.dc)) ||
                         (f_rtv(e1.dc) && f_rt(e1.dc) == f_rd(e0.dc)) ||
                         (f_rdv(e1.dc) && f_rd(e1.dc) == f_rd(e0.dc)));
               if (compat && !hazard && rb1 && rb2 &&
                   !(f_rdv(e1.dc) && m_busy[f_rd(e1.dc)]) && pf[p1]) nl = 2;
            end
         end
      end
      // scoreboard
      nb = m_busy;
      for (int i = 0; i < NWB; i++) if (wb_en[i]) nb[wb_addr[i]] = 1'b0;
      if (flush) begin
         for (int k = 0; k < 2; k++)
            if (m_exv[k] && !rdy_in[k] && f_rdv(m_ex[k].dc)) nb[f_rd(m_ex[k].dc)] = 1'b0;
      end
      if (nl >= 1 && f_rdv(e0.dc)) nb[f_rd(e0.dc)] = 1'b1;
      if (nl == 2 && f_rdv(e1.dc)) nb[f_rd(e1.dc)] = 1'b1;
      nb[0] = 1'b0;
      // output stage
      loaded[0] = 1'b0; loaded[1] = 1'b0;
      if (nl >= 1) begin
         m_exv[p0] = 1'b1; m_ex[p0] = e0; m_op1[p0] = a1; m_op2[p0] = a2; loaded[p0] = 1'b1;
      end
      if (nl == 2) begin
         m_exv[p1] = 1'b1; m_ex[p1] = e1; m_op1[p1] = b1; m_op2[p1] = b2; loaded[p1] = 1'b1;
      end
      for (int k = 0; k < 2; k++)
         if (!loaded[k] && (flush || rdy_in[k])) m_exv[k] = 1'b0;
      // queue
      if (flush) q.delete();
      else begin
         repeat (nl) void'(q.pop_front());
         if (can_enq && in_valid[0]) begin
            q.push_back('{in0_pc, in0_npc, in0_dc});
            if (in_valid[1]) q.push_back('{in1_pc, in1_npc, in1_dc});
         end
      end
      m_busy = nb;
   endtask

   // ----------------------------------------------------------- scoreboard
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("in_ready",  in_ready,  q.size() <= DEPTH - 2);
      check("ex0_valid", ex0_valid, m_exv[0]);
      check("ex0_pc",    ex0_pc,    m_ex[0].pc);
      check("ex0_npc",   ex0_npc,   m_ex[0].npc);
      check("ex0_dc",    ex0_dc,    m_ex[0].dc);
      check("ex0_op1",   ex0_op1,   m_op1[0]);
      check("ex0_op2",   ex0_op2,   m_op2[0]);
      check("ex1_valid", ex1_valid, m_exv[1]);
      check("ex1_pc",    ex1_pc,    m_ex[1].pc);
      check("ex1_npc",   ex1_npc,   m_ex[1].npc);
      check("ex1_dc",    ex1_dc,    m_ex[1].dc);
      check("ex1_op1",   ex1_op1,   m_op1[1]);
      check("ex1_op2",   ex1_op2,   m_op2[1]);
   endtask

   // ------------------------------------------------------------- drivers
   int              pc_ctr = 16;
   logic [PC_W-1:0] slot_pc [2];

   function automatic logic [DC_W-1:0] mk_dc(int t, int rd, int rdv, int rs, int rsv,
                                             int rt, int rtv);
      logic [DC_W-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[4:0]   = 5'(rs);
      d[5]     = 1'(rsv);
      d[10:6]  = 5'(rt);
      d[11]    = 1'(rtv);
      d[16:12] = 5'(rd);
      d[17]    = 1'(rdv);
      d[19:18] = 2'(t);
      return d;
   endfunction

   task automatic set_slot(input int s, input int t, input int rd, input int rdv,
                           input int rs, input int rsv, input int rt, input int rtv);
      logic [PC_W-1:0] pc;
      pc = PC_W'(pc_ctr) << 2;
      pc_ctr++;
      slot_pc[s] = pc;
      if (s == 0) begin
         in0_pc = pc; in0_npc = pc + 4; in0_dc = mk_dc(t, rd, rdv, rs, rsv, rt, rtv);
      end else begin
         in1_pc = pc; in1_npc = pc + 4; in1_dc = mk_dc(t, rd, rdv, rs, rsv, rt, rtv);
      end
   endtask

   task automatic idle();
      rst = 1'b1; flush = 1'b0; in_valid = 2'b00; wb_en = '0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      for (int i = 0; i < 32; i++) rf_model[i] = (i == 0) ? '0 : $urandom;
      for (int k = 0; k < 2; k++) begin
         m_exv[k] = 1'b0; m_ex[k] = '0; m_op1[k] = '0; m_op2[k] = '0;
      end
      m_busy = '0;

      // Reset state
      do_reset();
      do_reset();
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_ex0_valid", ex0_valid, 1'b0);
      check("reset_ex1_pc", ex1_pc, '0);

      // Reset mid-stream with five entries queued
      ex0_ready = 1'b0; ex1_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         set_slot(0, BR, 0, 0, 1, 1, 2, 1);
         set_slot(1, BR, 0, 0, 3, 1, 4, 1);
         in_valid = 2'b11;
         tick();
      end
      idle();
      check("midrst_in_ready_pre", in_ready, 1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_ex0_valid", ex0_valid, 1'b0);
      ex0_ready = 1'b1; ex1_ready = 1'b1;

      // Pair launch: AL then BR, appear two cycles after enqueue
      do_reset();
      set_slot(0, AL, 1, 1, 2, 1, 3, 1);
      set_slot(1, BR, 0, 0, 4, 1, 5, 1);
      in_valid = 2'b11;
      tick();
      idle();
      check("pair_not_yet", ex1_valid, 1'b0);
      tick();
      check("pair_ex1_pc", ex1_pc, slot_pc[0]);
      check("pair_ex0_pc", ex0_pc, slot_pc[1]);
      check("pair_ex1_op1", ex1_op1, rf_model[2]);

      // RAW with same-cycle forwarding
      do_reset();
      set_slot(0, AL, 5, 1, 1, 1, 2, 1);
      set_slot(1, AL, 6, 1, 5, 1, 0, 0);
      in_valid = 2'b11;
      tick();
      idle();
      tick();
      tick();
      check("raw_held", ex0_valid, 1'b0);
      wb_en = 4'b0101;
      wb_addr[0] = 5'd5; wb_data[0] = 32'hDEADBEEF;
      wb_addr[2] = 5'd5; wb_data[2] = 32'h12345678;
      tick();
      idle();
      check("raw_fwd_valid", ex0_valid, 1'b1);
      check("raw_fwd_pc", ex0_pc, slot_pc[1]);
      check("raw_fwd_op1", ex0_op1, 32'hDEADBEEF);
      check("raw_fwd_op2", ex0_op2, 32'h0);

      // Pipe stall on pipe1 with two AGs
      do_reset();
      ex1_ready = 1'b0;
      set_slot(0, AG, 0, 0, 1, 1, 2, 1);
      set_slot(1, AG, 0, 0, 3, 1, 4, 1);
      in_valid = 2'b11;
      tick();
      idle();
      for (int c = 0; c < 3; c++) tick();
      check("stall_ex1_holds", ex1_pc, slot_pc[0]);
      ex1_ready = 1'b1;
      tick();
      check("stall_second", ex1_pc, slot_pc[1]);
      tick();
      check("stall_drained", ex1_valid, 1'b0);

      // Full queue and pointer wrap
      do_reset();
      ex0_ready = 1'b0; ex1_ready = 1'b0;
      set_slot(0, BR, 0, 0, 1, 1, 2, 1);
      in_valid = 2'b01;
      tick();
      for (int c = 0; c < 4; c++) begin
         set_slot(0, BR, 0, 0, 1, 1, 2, 1);
         set_slot(1, BR, 0, 0, 3, 1, 4, 1);
         in_valid = 2'b11;
         tick();
      end
      check("full_in_ready", in_ready, 1'b0);
      ex0_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         set_slot(0, BR, 0, 0, 1, 1, 2, 1);
         set_slot(1, AL, 0, 0, 3, 1, 4, 1);
         in_valid = 2'b11;
         tick();
         if (c == 0) check("full_one_slot", in_ready, 1'b0);
      end
      idle();
      ex1_ready = 1'b1;
      for (int c = 0; c < 12; c++) tick();

      // Flush with ex0 stalled holding rd=x7
      do_reset();
      ex0_ready = 1'b0;
      set_slot(0, BR, 7, 1, 1, 1, 2, 1);
      in_valid = 2'b01;
      tick();
      idle();
      tick();
      check("flush_pre_valid", ex0_valid, 1'b1);
      flush = 1'b1;
      set_slot(0, AL, 3, 1, 1, 1, 2, 1);
      set_slot(1, AL, 4, 1, 1, 1, 2, 1);
      in_valid = 2'b11;
      tick();
      idle();
      check("flush_ex0_valid", ex0_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      ex0_ready = 1'b1;
      tick();
      check("flush_no_enq", ex0_valid, 1'b0);
      set_slot(0, AL, 8, 1, 7, 1, 0, 0);
      in_valid = 2'b01;
      tick();
      idle();
      tick();
      check("flush_x7_free", ex0_pc, slot_pc[0]);
      check("flush_x7_op1", ex0_op1, rf_model[7]);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 199) != 0);
         flush = ($urandom_range(0, 39) == 0);
         in_valid = 2'($urandom_range(0, 3));
         set_slot(0, $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1));
         set_slot(1, $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1));
         for (int i = 0; i < NWB; i++) begin
            wb_en[i]   = ($urandom_range(0, 3) == 0);
            wb_addr[i] = 5'($urandom_range(1, 7));
            wb_data[i] = $urandom;
         end
         ex0_ready = ($urandom_range(0, 3) != 0);
         ex1_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
